// File: rtl/hilo_fwd_if.sv
// HI/LO forwarding file bus: EX-stage read/write flags and data, pipeline
// control, forwarded read data and architectural HI/LO visibility.
interface hilo_fwd_if #(
  parameter int DW = 32
);
  logic [2:0]    ex_rd_flag;
  logic [2:0]    ex_wr_flag;
  logic [DW-1:0] ex_wr_hi;
  logic [DW-1:0] ex_wr_lo;
  logic          stall;
  logic          flush;
  logic [DW-1:0] ex_rd_data;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;
  logic          m_pending;
  logic          w_pending;

  // Pipeline side: drives flags/data/control, observes results.
  modport master (
    output ex_rd_flag, ex_wr_flag, ex_wr_hi, ex_wr_lo, stall, flush,
    input  ex_rd_data, hi_o, lo_o, m_pending, w_pending
  );

  // Register file side.
  modport slave (
    input  ex_rd_flag, ex_wr_flag, ex_wr_hi, ex_wr_lo, stall, flush,
    output ex_rd_data, hi_o, lo_o, m_pending, w_pending
  );
endinterface

// File: rtl/hilo_fwd_file.sv
// HI/LO register file with an M/W write pipeline and same-cycle read
// forwarding for EX-stage MFHI/MFLO. Each half (HI, LO) is forwarded
// independently so partial writes (MTHI/MTLO) resolve from the youngest
// entry that actually writes that half.
module hilo_fwd_file #(
  parameter int DW = 32
) (
  input  logic        clk,
  input  logic        resetn,
  hilo_fwd_if.slave   bus
);

  typedef struct packed {
    logic          valid;
    logic          hi_en;
    logic          lo_en;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } ent_t;

  // A flag is a real write only when active and at least one half is selected.
  function automatic logic flag_wr_valid(input logic [2:0] f);
    return f[2] & (f[1] | f[0]);
  endfunction

  ent_t          ex_ent_s;
  ent_t          m_q, m_d;
  ent_t          w_q, w_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [DW-1:0] fwd_hi_s;
  logic [DW-1:0] fwd_lo_s;
  logic [DW-1:0] rd_data_s;

  // Build the EX write entry; non-writes become an all-zero bubble.
  always_comb begin
    ex_ent_s = '0;
    if (flag_wr_valid(bus.ex_wr_flag)) begin
      ex_ent_s.valid = 1'b1;
      ex_ent_s.hi_en = bus.ex_wr_flag[1];
      ex_ent_s.lo_en = bus.ex_wr_flag[0];
      ex_ent_s.hi    = bus.ex_wr_hi;
      ex_ent_s.lo    = bus.ex_wr_lo;
    end else begin
      ex_ent_s = '0;
    end
  end

  // Advance the M/W pipeline: flush kills M and EX, stall holds M and bubbles W.
  always_comb begin
    m_d = m_q;
    w_d = w_q;
    if (bus.flush) begin
      m_d = '0;
      w_d = '0;
    end else if (bus.stall) begin
      m_d = m_q;
      w_d = '0;
    end else begin
      m_d = ex_ent_s;
      w_d = m_q;
    end
  end

  // Commit the W entry into the architectural registers, per enabled half.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (w_q.valid && w_q.hi_en) begin
      hi_d = w_q.hi;
    end else begin
      hi_d = hi_q;
    end
    if (w_q.valid && w_q.lo_en) begin
      lo_d = w_q.lo;
    end else begin
      lo_d = lo_q;
    end
  end

  // Forward each half from the youngest pending writer, else architectural state.
  always_comb begin
    fwd_hi_s = hi_q;
    fwd_lo_s = lo_q;
    if (m_q.valid && m_q.hi_en) begin
      fwd_hi_s = m_q.hi;
    end else if (w_q.valid && w_q.hi_en) begin
      fwd_hi_s = w_q.hi;
    end else begin
      fwd_hi_s = hi_q;
    end
    if (m_q.valid && m_q.lo_en) begin
      fwd_lo_s = m_q.lo;
    end else if (w_q.valid && w_q.lo_en) begin
      fwd_lo_s = w_q.lo;
    end else begin
      fwd_lo_s = lo_q;
    end
  end

  // Select the read half; an inactive read flag returns zero.
  always_comb begin
    rd_data_s = '0;
    if (bus.ex_rd_flag[2]) begin
      if (bus.ex_rd_flag[1]) begin
        rd_data_s = fwd_hi_s;
      end else begin
        rd_data_s = fwd_lo_s;
      end
    end else begin
      rd_data_s = '0;
    end
  end

  // State registers; reset discards any pending M/W writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_q  <= '0;
      w_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      m_q  <= m_d;
      w_q  <= w_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.ex_rd_data = rd_data_s;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;
  assign bus.m_pending  = m_q.valid;
  assign bus.w_pending  = w_q.valid;

endmodule
